// File: rtl/rr_switch_pkg.sv
// rr_switch_pkg: flit and FSM types plus flit field helpers for the switch.
package rr_switch_pkg;

    localparam int MAXW  = 64;
    localparam int MAXPW = 4;

    typedef enum logic [1:0] {
        F_IDLE = 2'b00,
        F_BODY = 2'b01,
        F_HEAD = 2'b10,
        F_TAIL = 2'b11
    } flit_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    // Helpers take a zero-extended flit so one function serves every width.
    function automatic flit_t flit_type(input logic [MAXW-1:0] f, input int fw);
        return flit_t'(2'(f >> (fw - 2)));
    endfunction

    function automatic logic [MAXW-1:0] flit_payload(input logic [MAXW-1:0] f, input int fw);
        return f & ((MAXW'(1) << (fw - 2)) - MAXW'(1));
    endfunction

    function automatic logic [MAXPW-1:0] flit_dest(input logic [MAXW-1:0] f, input int pw);
        return MAXPW'(f & ((MAXW'(1) << pw) - MAXW'(1)));
    endfunction

endpackage

// File: rtl/rr_switch_if.sv
// rr_switch_if: flattened input/output flit buses and per-input ready.
interface rr_switch_if #(
    parameter int NPORT = 4,
    parameter int DATAW = 8
);
    localparam int FW = DATAW + 2;

    logic [NPORT*FW-1:0] i_flit;
    logic [NPORT-1:0]    i_ready;
    logic [NPORT*FW-1:0] o_flit;

    modport master (output i_flit, input i_ready, o_flit);
    modport slave  (input i_flit, output i_ready, o_flit);
endinterface

// File: rtl/rr_fifo.sv
// rr_fifo: synchronous FIFO with a combinational head and registered count.
module rr_fifo #(
    parameter int W = 10,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;

    assign full  = cnt_q == (AW+1)'(D);
    assign empty = cnt_q == '0;
    assign dout  = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wp_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)
                wp_q <= wp_q + 1'b1;
            if (pop)
                rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/rr_switch.sv
// rr_switch: NPORT x NPORT wormhole switch, one FIFO per input and a
// round-robin IDLE/BUSY arbiter per output with a registered output flit.
module rr_switch
    import rr_switch_pkg::*;
#(
    parameter int NPORT = 4,
    parameter int DATAW = 8,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    rr_switch_if.slave sw
);
    localparam int PW = $clog2(NPORT);
    localparam int FW = DATAW + 2;

    logic [NPORT-1:0] push, pop, full, empty, owned, stray;
    logic [FW-1:0]    head  [NPORT];
    logic [NPORT-1:0] pop_m [NPORT];
    logic             busy  [NPORT];
    logic [PW-1:0]    owner [NPORT];

    assign sw.i_ready = ~full;

    always_comb begin
        owned = '0;
        for (int o = 0; o < NPORT; o++)
            if (busy[o])
                owned[owner[o]] = 1'b1;
    end

    // Ownership is exclusive, so at most one source pops any FIFO per cycle.
    always_comb begin
        pop = stray;
        for (int o = 0; o < NPORT; o++)
            pop = pop | pop_m[o];
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_in
        logic [FW-1:0] f;
        assign f        = sw.i_flit[p*FW +: FW];
        assign push[p]  = flit_type(MAXW'(f), FW) != F_IDLE && !full[p];
        assign stray[p] = !empty[p] && !owned[p] &&
                          flit_type(MAXW'(head[p]), FW) inside {F_BODY, F_TAIL};
        rr_fifo #(.W(FW), .D(DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[p]),
            .pop   (pop[p]),
            .din   (f),
            .dout  (head[p]),
            .full  (full[p]),
            .empty (empty[p])
        );
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_out
        state_t           st_q, st_d;
        logic [PW-1:0]    own_q, own_d, last_q, last_d, sel;
        logic [FW-1:0]    out_q, out_d;
        logic [NPORT-1:0] req, pm;
        logic             hit;

        always_comb begin
            req = '0;
            for (int p = 0; p < NPORT; p++)
                req[p] = !empty[p] && !owned[p] &&
                         flit_type(MAXW'(head[p]), FW) == F_HEAD &&
                         flit_dest(MAXW'(head[p]), PW) == MAXPW'(o);
            hit = 1'b0;
            sel = last_q;
            // Scan downward so the nearest requester after last_q is kept.
            for (int k = NPORT; k >= 1; k--)
                if (req[last_q + PW'(k)]) begin
                    hit = 1'b1;
                    sel = last_q + PW'(k);
                end
        end

        always_comb begin
            st_d   = st_q;
            own_d  = own_q;
            last_d = last_q;
            out_d  = '0;
            pm     = '0;
            if (st_q == S_IDLE) begin
                if (hit) begin
                    pm[sel] = 1'b1;
                    out_d   = head[sel];
                    own_d   = sel;
                    st_d    = S_BUSY;
                end
            end else if (!empty[own_q]) begin
                pm[own_q] = 1'b1;
                out_d     = head[own_q];
                if (flit_type(MAXW'(head[own_q]), FW) == F_TAIL) begin
                    st_d   = S_IDLE;
                    last_d = own_q;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= S_IDLE;
                own_q  <= '0;
                last_q <= PW'(NPORT - 1);
                out_q  <= '0;
            end else begin
                st_q   <= st_d;
                own_q  <= own_d;
                last_q <= last_d;
                out_q  <= out_d;
            end
        end

        assign busy[o]                 = st_q == S_BUSY;
        assign owner[o]                = own_q;
        assign pop_m[o]                = pm;
        assign sw.o_flit[o*FW +: FW]   = out_q;
    end
endmodule

// File: tb/tb_rr_switch.sv
// tb_rr_switch: directed and randomized traffic against a queue-based model.
module tb_rr_switch;
    localparam int NPORT = 4;
    localparam int DATAW = 8;
    localparam int DEPTH = 4;
    localparam int FW    = DATAW + 2;
    localparam int NW    = NPORT * FW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_switch_if #(.NPORT(NPORT), .DATAW(DATAW)) sw ();
    rr_switch #(.NPORT(NPORT), .DATAW(DATAW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    int total = 0;
    int bad   = 0;

    logic [FW-1:0]    mq [NPORT][$];
    logic             mbusy [NPORT];
    int               mown  [NPORT];
    int               mlast [NPORT];
    logic [FW-1:0]    mout  [NPORT];
    logic [NPORT-1:0] mready;
    logic [NPORT-1:0] rdy;

    function automatic logic [FW-1:0] mk(input int src, input int k, input int dst, input int len);
        logic [1:0] t;
        t = (k == 0) ? 2'b10 : (k == len - 1) ? 2'b11 : 2'b01;
        return {t, 2'(src), 4'(k), 2'(dst)};
    endfunction

    // Packets sit in per-input queues; each output either grants the first
    // waiting HEAD after its last grant or drains its owner's queue.
    task automatic model(input logic [NW-1:0] v, input logic r);
        logic [NPORT-1:0] owned, popd;
        logic [FW-1:0]    f;
        int               sz [NPORT];
        int               q;
        if (r) begin
            for (int p = 0; p < NPORT; p++) mq[p].delete();
            for (int o = 0; o < NPORT; o++) begin
                mbusy[o] = 1'b0;
                mown[o]  = 0;
                mlast[o] = NPORT - 1;
                mout[o]  = '0;
            end
            mready = '1;
            return;
        end
        owned = '0;
        popd  = '0;
        for (int p = 0; p < NPORT; p++) sz[p] = mq[p].size();
        for (int o = 0; o < NPORT; o++) if (mbusy[o]) owned[mown[o]] = 1'b1;
        for (int o = 0; o < NPORT; o++) begin
            mout[o] = '0;
            if (mbusy[o]) begin
                if (sz[mown[o]] > 0) begin
                    mout[o] = mq[mown[o]][0];
                    popd[mown[o]] = 1'b1;
                    if (mout[o][FW-1:FW-2] == 2'b11) begin
                        mbusy[o] = 1'b0;
                        mlast[o] = mown[o];
                    end
                end
            end else begin
                for (int k = 1; k <= NPORT && !mbusy[o]; k++) begin
                    q = (mlast[o] + k) % NPORT;
                    if (!owned[q] && sz[q] > 0 && mq[q][0][FW-1:FW-2] == 2'b10 &&
                        int'(mq[q][0][1:0]) == o) begin
                        mbusy[o] = 1'b1;
                        mown[o]  = q;
                        mout[o]  = mq[q][0];
                        popd[q]  = 1'b1;
                    end
                end
            end
        end
        for (int p = 0; p < NPORT; p++)
            if (!popd[p] && !owned[p] && sz[p] > 0 && mq[p][0][FW-2])
                popd[p] = 1'b1;
        for (int p = 0; p < NPORT; p++) begin
            f = v[p*FW +: FW];
            if (popd[p]) void'(mq[p].pop_front());
            if (f[FW-1:FW-2] != 2'b00 && sz[p] < DEPTH) mq[p].push_back(f);
            mready[p] = mq[p].size() < DEPTH;
        end
    endtask

    task automatic step(input logic [NW-1:0] v, input logic r);
        sw.i_flit = v;
        rst       = r;
        rdy       = sw.i_ready;
        model(v, r);
        @(posedge clk);
        #1;
        for (int o = 0; o < NPORT; o++) begin
            total++;
            if (sw.o_flit[o*FW +: FW] !== mout[o]) begin
                bad++;
                $display("FAIL model_out%0d @%0t: got %h want %h", o, $time, sw.o_flit[o*FW +: FW], mout[o]);
            end
        end
        total++;
        if (sw.i_ready !== mready) begin
            bad++;
            $display("FAIL model_ready @%0t: got %b want %b", $time, sw.i_ready, mready);
        end
    endtask

    task automatic chk(input string n, input logic [NW-1:0] got, input logic [NW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", n, $time, got, want);
        end
    endtask

    initial begin
        logic [NW-1:0] v, w;
        logic [FW-1:0] got [$];
        logic [FW-1:0] p0 [4];
        logic [FW-1:0] cur [NPORT];
        logic          hold [NPORT];
        int            len [NPORT], pos [NPORT], dst [NPORT];
        int            idx [2];
        logic          r;

        sw.i_flit = '0;
        step('0, 1'b1);
        step('0, 1'b1);
        chk("reset_out", sw.o_flit, '0);
        chk("reset_ready", NW'(sw.i_ready), NW'(4'b1111));

        p0 = '{10'b10_0000_0001, 10'b01_0000_0000, 10'b01_0000_0001, 10'b11_0000_0010};
        for (int i = 0; i < 6; i++) begin
            step(i < 4 ? NW'(p0[i]) : '0, 1'b0);
            chk("single", sw.o_flit, (i >= 1 && i <= 4) ? NW'(p0[(i + 3) % 4]) << FW : '0);
        end

        step('0, 1'b1);
        for (int i = 0; i < 18; i++) begin
            v = '0;
            if (i < 4) for (int p = 0; p < NPORT; p++) v[p*FW +: FW] = mk(p, i, 1, 4);
            step(v, 1'b0);
            if (i >= 1)
                chk("conflict", sw.o_flit, i <= 16 ? NW'(mk((i - 1) / 4, (i - 1) % 4, 1, 4)) << FW : '0);
        end

        step('0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            v = '0;
            w = '0;
            for (int p = 0; p < NPORT; p++) begin
                if (i < 2) v[p*FW +: FW] = mk(p, i, (p + 1) % NPORT, 2);
                if (i == 1 || i == 2) w[p*FW +: FW] = mk((p + NPORT - 1) % NPORT, i - 1, p, 2);
            end
            step(v, 1'b0);
            chk("parallel", sw.o_flit, w);
        end

        step('0, 1'b1);
        idx = '{0, 0};
        got.delete();
        for (int c = 0; c < 30; c++) begin
            v = '0;
            for (int p = 0; p < 2; p++) if (idx[p] < 8) v[p*FW +: FW] = mk(p, idx[p], 2, 8);
            step(v, 1'b0);
            for (int p = 0; p < 2; p++)
                if (idx[p] < 8 && rdy[p]) begin
                    idx[p]++;
                    if (p == 1 && idx[p] == 3) chk("bp_not_full", NW'(sw.i_ready[1]), NW'(1));
                    if (p == 1 && idx[p] == 4) chk("bp_full", NW'(sw.i_ready[1]), '0);
                end
            if (sw.o_flit[2*FW +: FW] != '0) got.push_back(sw.o_flit[2*FW +: FW]);
        end
        chk("bp_count", NW'(got.size()), NW'(16));
        for (int k = 0; k < 16 && k < got.size(); k++)
            chk("bp_order", NW'(got[k]), NW'(mk(k / 8, k % 8, 2, 8)));

        step('0, 1'b1);
        step(NW'(10'b01_0000_0101) << (3 * FW), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step('0, 1'b0);
            chk("stray", sw.o_flit, '0);
        end

        step(NW'(mk(2, 0, 0, 3)) << (2 * FW), 1'b0);
        step(NW'(mk(2, 1, 0, 3)) << (2 * FW), 1'b0);
        step('0, 1'b1);
        chk("midrst", sw.o_flit, '0);
        step(NW'(mk(2, 2, 0, 3)) << (2 * FW), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step('0, 1'b0);
            chk("midrst_no_tail", sw.o_flit, '0);
        end

        for (int p = 0; p < NPORT; p++) begin
            len[p]  = 0;
            pos[p]  = 0;
            dst[p]  = 0;
            hold[p] = 1'b0;
            cur[p]  = '0;
        end
        for (int c = 0; c < 2000; c++) begin
            r = (c == 1000);
            for (int p = 0; p < NPORT; p++)
                if (!hold[p]) begin
                    if (len[p] == 0) begin
                        cur[p] = '0;
                        if ($urandom_range(0, 2) == 0) begin
                            len[p] = $urandom_range(2, 6);
                            pos[p] = 0;
                            dst[p] = $urandom_range(0, NPORT - 1);
                        end else if ($urandom_range(0, 49) == 0)
                            cur[p] = {2'b01, 8'($urandom)};
                    end
                    if (len[p] != 0)
                        cur[p] = ($urandom_range(0, 4) == 0) ? '0 : mk(p, pos[p], dst[p], len[p]);
                end
            v = '0;
            for (int p = 0; p < NPORT; p++) v[p*FW +: FW] = cur[p];
            step(v, r);
            for (int p = 0; p < NPORT; p++) begin
                hold[p] = cur[p] != '0 && !rdy[p];
                if (cur[p] != '0 && rdy[p] && len[p] != 0) begin
                    pos[p]++;
                    if (pos[p] == len[p]) len[p] = 0;
                end
                if (r) begin
                    len[p]  = 0;
                    hold[p] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 40; i++) step('0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
